// File: rtl/rr_interconnect.sv
// rr_interconnect: round-robin interconnect between NUM_MASTERS masters and NUM_SLAVES slaves.
// One transaction is in flight at a time (IDLE -> ACCESS -> RESP). A decode miss skips ACCESS
// and answers the master with an error.
// Optional feature: define RR_INTERCONNECT_TIMEOUT_EN to compile in an ACCESS watchdog that
// ends a slave access with an error after TIMEOUT_CYCLES cycles without slave_ready.
module rr_interconnect #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3100_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hE000_0000},
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_MASTERS-1:0]                        master_req,
  input  logic [NUM_MASTERS-1:0]                        master_we,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]        master_addr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        master_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]      master_be,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        master_rdata,
  output logic [NUM_MASTERS-1:0]                        master_ready,
  output logic [NUM_MASTERS-1:0]                        master_err,
  output logic [NUM_SLAVES-1:0]                         slave_req,
  output logic [NUM_SLAVES-1:0]                         slave_we,
  output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]         slave_addr,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]         slave_wdata,
  output logic [NUM_SLAVES-1:0][DATA_WIDTH/8-1:0]       slave_be,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]         slave_rdata,
  input  logic [NUM_SLAVES-1:0]                         slave_ready
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned IdW  = $clog2(NUM_MASTERS);
  localparam int unsigned SelW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        last_q, last_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BeW-1:0]        be_q, be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

`ifdef RR_INTERCONNECT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0]       cnt_q, cnt_d;
`endif

  logic                  grant_found;
  logic [IdW-1:0]        grant_id;
  logic                  dec_hit;
  logic [SelW-1:0]       dec_sel;

  // Master index reached by stepping 'off' places past 'last', wrapping at NUM_MASTERS.
  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] last, input int unsigned off);
    logic [31:0] sum;
    sum = (32'(last) + off) % NUM_MASTERS;
    return IdW'(sum);
  endfunction

  // Round-robin pick: first requesting master after the last grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = last_q;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      if (!grant_found && master_req[rr_idx(last_q, i)]) begin
        grant_found = 1'b1;
        grant_id    = rr_idx(last_q, i);
      end
    end
  end

  // Address decode of the candidate master; lowest matching slave index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (!dec_hit && ((master_addr[grant_id] & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
                       SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec_hit = 1'b1;
        dec_sel = SelW'(s);
      end
    end
  end

  // Next-state logic: grant and latch in IDLE, wait for the slave in ACCESS, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef RR_INTERCONNECT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          last_d  = grant_id;
          id_d    = grant_id;
          sel_d   = dec_sel;
          we_d    = master_we[grant_id];
          addr_d  = master_addr[grant_id];
          wdata_d = master_wdata[grant_id];
          be_d    = master_be[grant_id];
          if (dec_hit) begin
            state_d = StAccess;
            err_d   = 1'b0;
`ifdef RR_INTERCONNECT_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Unmapped address: answer directly, no slave is touched.
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      StAccess: begin
        if (slave_ready[sel_q]) begin
          state_d = StResp;
          rdata_d = slave_rdata[sel_q];
          err_d   = 1'b0;
        end
`ifdef RR_INTERCONNECT_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; master 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= IdW'(NUM_MASTERS - 1);
      id_q    <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef RR_INTERCONNECT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef RR_INTERCONNECT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Outputs: only the selected slave is driven in ACCESS, only the owning master in RESP.
  always_comb begin
    slave_req    = '0;
    slave_we     = '0;
    slave_addr   = '0;
    slave_wdata  = '0;
    slave_be     = '0;
    master_ready = '0;
    master_err   = '0;
    master_rdata = '0;
    if (state_q == StAccess) begin
      slave_req[sel_q]   = 1'b1;
      slave_we[sel_q]    = we_q;
      slave_addr[sel_q]  = addr_q;
      slave_wdata[sel_q] = wdata_q;
      slave_be[sel_q]    = be_q;
    end
    if (state_q == StResp) begin
      master_ready[id_q] = 1'b1;
      master_err[id_q]   = err_q;
      master_rdata[id_q] = rdata_q;
    end
  end

endmodule

// File: tb/tb_rr_interconnect.sv
// Self-checking bench for rr_interconnect: directed vector table, hand-written corner
// sequences and a randomized transaction-level reference model.
module tb_rr_interconnect;

  localparam int NM = 3;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 4;
  localparam logic [NS*AW-1:0] BASE =
    {32'h3100_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK =
    {32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hE000_0000};

  logic                      clk;
  logic                      rst;
  logic [NM-1:0]             master_req;
  logic [NM-1:0]             master_we;
  logic [NM-1:0][AW-1:0]     master_addr;
  logic [NM-1:0][DW-1:0]     master_wdata;
  logic [NM-1:0][BW-1:0]     master_be;
  logic [NM-1:0][DW-1:0]     master_rdata;
  logic [NM-1:0]             master_ready;
  logic [NM-1:0]             master_err;
  logic [NS-1:0]             slave_req;
  logic [NS-1:0]             slave_we;
  logic [NS-1:0][AW-1:0]     slave_addr;
  logic [NS-1:0][DW-1:0]     slave_wdata;
  logic [NS-1:0][BW-1:0]     slave_be;
  logic [NS-1:0][DW-1:0]     slave_rdata;
  logic [NS-1:0]             slave_ready;

  int n_chk  = 0;
  int n_fail = 0;

  rr_interconnect #(
    .NUM_MASTERS   (NM),
    .NUM_SLAVES    (NS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SLAVE_BASE    (BASE),
    .SLAVE_MASK    (MASK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .master_req  (master_req),
    .master_we   (master_we),
    .master_addr (master_addr),
    .master_wdata(master_wdata),
    .master_be   (master_be),
    .master_rdata(master_rdata),
    .master_ready(master_ready),
    .master_err  (master_err),
    .slave_req   (slave_req),
    .slave_we    (slave_we),
    .slave_addr  (slave_addr),
    .slave_wdata (slave_wdata),
    .slave_be    (slave_be),
    .slave_rdata (slave_rdata),
    .slave_ready (slave_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] sdata;
    int          exp_s;  // expected slave, -1 for a decode miss
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    master_req   = '0;
    master_we    = '0;
    master_addr  = '0;
    master_wdata = '0;
    master_be    = '0;
    slave_ready  = '0;
    slave_rdata  = '0;
  endtask

  function automatic logic all_zero();
    return (master_rdata == '0) && (master_ready == '0) && (master_err == '0) &&
           (slave_req == '0) && (slave_we == '0) && (slave_addr == '0) &&
           (slave_wdata == '0) && (slave_be == '0);
  endfunction

  // Reference decode straight from the address map: lowest matching slave, -1 if none.
  function automatic int ref_decode(input logic [31:0] a);
    logic [NS*AW-1:0] b;
    logic [NS*AW-1:0] k;
    b = BASE;
    k = MASK;
    for (int s = 0; s < NS; s++) begin
      if ((a & k[s*AW +: AW]) == b[s*AW +: AW]) return s;
    end
    return -1;
  endfunction

  task automatic new_req(input int m);
    logic [31:0] r;
    r = $urandom;
    master_req[m]   = 1'b1;
    master_we[m]    = 1'($urandom_range(0, 1));
    master_wdata[m] = $urandom;
    master_be[m]    = 4'($urandom);
    case ($urandom_range(0, 5))
      0: master_addr[m] = {3'b000, r[28:0]};
      1: master_addr[m] = {4'h2, r[27:0]};
      2: master_addr[m] = {8'h30, r[23:0]};
      3: master_addr[m] = {8'h31, r[23:0]};
      4: master_addr[m] = {4'h4, r[27:0]};
      default: master_addr[m] = {8'h32, r[23:0]};
    endcase
  endtask

  initial begin
    int          exp_m;
    int          s;
    int          lat;
    int          model_last;
    logic [31:0] d;
    logic [31:0] a;

    vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 0};
    vecs[1] = '{1, 1'b1, 32'h3000_0010, 32'h1234_5678, 4'b0011, 32'hCAFE_0001, 2};
    vecs[2] = '{2, 1'b0, 32'h4000_0000, 32'h0000_0000, 4'hF, 32'h7777_7777, -1};
    vecs[3] = '{0, 1'b0, 32'h1FFF_FFFC, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 0};
    vecs[4] = '{1, 1'b0, 32'h2000_0000, 32'h0000_0000, 4'hF, 32'h1111_2222, 1};
    vecs[5] = '{2, 1'b1, 32'h2FFF_FFF0, 32'hA5A5_5A5A, 4'b1000, 32'h0000_3333, 1};
    vecs[6] = '{0, 1'b0, 32'h30FF_FFFC, 32'h0000_0000, 4'hF, 32'h4444_5555, 2};
    vecs[7] = '{2, 1'b0, 32'h3100_0000, 32'h0000_0000, 4'hF, 32'h6666_8888, 3};
    vecs[8] = '{1, 1'b1, 32'h3200_0000, 32'hFFFF_0000, 4'hF, 32'h9999_9999, -1};
    vecs[9] = '{0, 1'b0, 32'hE000_0000, 32'h0000_0000, 4'hF, 32'hAAAA_BBBB, -1};

    // Reset: outputs stay zero even with requests pending during reset.
    clear_inputs();
    rst = 1'b1;
    tick();
    master_req  = '1;
    master_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    tick();
    chk("reset_outputs_zero", 128'(all_zero()), 128'(1));
    clear_inputs();
    rst = 1'b0;
    tick();
    chk("post_reset_outputs_zero", 128'(all_zero()), 128'(1));

    // All three masters request continuously: grants 0,1,2,0.
    master_req  = '1;
    master_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 4; k++) begin
      exp_m = k % NM;
      tick();
      chk("rr_slave_req", 128'(slave_req), 128'(1));
      chk("rr_slave_addr", 128'(slave_addr[0]), 128'(32'h100 * (exp_m + 1)));
      slave_ready[0] = 1'b1;
      slave_rdata[0] = 32'h55 + 32'(k);
      tick();
      slave_ready = '0;
      chk("rr_master_ready", 128'(master_ready), 128'(1) << exp_m);
      chk("rr_master_rdata", 128'(master_rdata), 128'(32'h55 + 32'(k)) << (32 * exp_m));
      tick();
      chk("rr_idle_quiet", 128'({master_ready, slave_req}), 128'(0));
    end
    clear_inputs();
    tick();

    // Vector table: single-master transactions, slave ready on the first ACCESS cycle.
    foreach (vecs[i]) begin
      clear_inputs();
      master_req[vecs[i].m]   = 1'b1;
      master_we[vecs[i].m]    = vecs[i].we;
      master_addr[vecs[i].m]  = vecs[i].addr;
      master_wdata[vecs[i].m] = vecs[i].wdata;
      master_be[vecs[i].m]    = vecs[i].be;
      tick();
      if (vecs[i].exp_s < 0) begin
        chk("vec_miss_no_slave", 128'({slave_req, slave_we}), 128'(0));
        chk("vec_miss_ready", 128'(master_ready), 128'(1) << vecs[i].m);
        chk("vec_miss_err", 128'(master_err), 128'(1) << vecs[i].m);
        chk("vec_miss_rdata", 128'(master_rdata), 128'(0));
      end else begin
        chk("vec_slave_req", 128'(slave_req), 128'(1) << vecs[i].exp_s);
        chk("vec_slave_we", 128'(slave_we), 128'(vecs[i].we) << vecs[i].exp_s);
        chk("vec_slave_addr", 128'(slave_addr[vecs[i].exp_s]), 128'(vecs[i].addr));
        chk("vec_slave_wdata", 128'(slave_wdata[vecs[i].exp_s]), 128'(vecs[i].wdata));
        chk("vec_slave_be", 128'(slave_be[vecs[i].exp_s]), 128'(vecs[i].be));
        chk("vec_no_early_ready", 128'(master_ready), 128'(0));
        slave_ready[vecs[i].exp_s] = 1'b1;
        slave_rdata[vecs[i].exp_s] = vecs[i].sdata;
        tick();
        slave_ready = '0;
        chk("vec_ready", 128'(master_ready), 128'(1) << vecs[i].m);
        chk("vec_err", 128'(master_err), 128'(0));
        chk("vec_rdata", 128'(master_rdata), 128'(vecs[i].sdata) << (32 * vecs[i].m));
        chk("vec_resp_slave_idle", 128'(slave_req), 128'(0));
      end
      master_req = '0;
      tick();
      chk("vec_idle_quiet", 128'(all_zero()), 128'(1));
    end

    // Slave 1 never answers.
    clear_inputs();
    master_req[1]  = 1'b1;
    master_addr[1] = 32'h2000_0040;
    tick();
    chk("wd_access", 128'(slave_req), 128'(4'b0010));
`ifdef RR_INTERCONNECT_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      tick();
      chk("wd_still_access", 128'({slave_req, master_ready}), 128'({4'b0010, 3'b000}));
    end
    tick();
    chk("wd_ready", 128'(master_ready), 128'(3'b010));
    chk("wd_err", 128'(master_err), 128'(3'b010));
    chk("wd_rdata", 128'(master_rdata), 128'(0));
    chk("wd_slave_dropped", 128'(slave_req), 128'(0));
    clear_inputs();
    tick();
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("nowd_waits", 128'({slave_req, master_ready}), 128'({4'b0010, 3'b000}));
    end
    slave_ready[1] = 1'b1;
    slave_rdata[1] = 32'h0123_4567;
    tick();
    chk("nowd_ready", 128'(master_ready), 128'(3'b010));
    chk("nowd_rdata", 128'(master_rdata), 128'(32'h0123_4567) << 32);
    clear_inputs();
    tick();
`endif

    // Reset during ACCESS abandons the transfer; next grant goes to master 0.
    clear_inputs();
    master_req[1]  = 1'b1;
    master_addr[1] = 32'h3000_0000;
    tick();
    chk("rst_mid_access", 128'(slave_req), 128'(4'b0100));
    rst = 1'b1;
    tick();
    chk("rst_mid_outputs_zero", 128'(all_zero()), 128'(1));
    rst = 1'b0;
    master_req  = '1;
    master_addr = {32'h0000_0300, 32'h3000_0000, 32'h0000_0100};
    tick();
    chk("rst_regrant_m0", 128'({slave_req, slave_addr[0]}), 128'({4'b0001, 32'h0000_0100}));
    slave_ready[0] = 1'b1;
    slave_rdata[0] = 32'h0000_BEEF;
    tick();
    chk("rst_regrant_ready", 128'(master_ready), 128'(3'b001));
    clear_inputs();
    tick();

    // Randomized traffic against a transaction-level round-robin model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = NM - 1;
    for (int t = 0; t < 150; t++) begin
      for (int m = 0; m < NM; m++) begin
        if (!master_req[m] && ($urandom_range(0, 1) == 1)) new_req(m);
      end
      if (master_req == '0) new_req($urandom_range(0, NM - 1));
      exp_m = -1;
      for (int i = 1; i <= NM; i++) begin
        if (exp_m < 0 && master_req[(model_last + i) % NM]) exp_m = (model_last + i) % NM;
      end
      model_last = exp_m;
      a = master_addr[exp_m];
      s = ref_decode(a);
      slave_ready = 4'($urandom);
      slave_rdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (s < 0) begin
        chk("rnd_miss_no_slave", 128'(slave_req), 128'(0));
        chk("rnd_miss_ready", 128'(master_ready), 128'(1) << exp_m);
        chk("rnd_miss_err", 128'(master_err), 128'(1) << exp_m);
        chk("rnd_miss_rdata", 128'(master_rdata), 128'(0));
      end else begin
        chk("rnd_slave_req", 128'(slave_req), 128'(1) << s);
        chk("rnd_slave_addr", 128'(slave_addr[s]), 128'(a));
        chk("rnd_slave_we", 128'(slave_we), 128'(master_we[exp_m]) << s);
        chk("rnd_slave_wdata", 128'(slave_wdata[s]), 128'(master_wdata[exp_m]));
        chk("rnd_slave_be", 128'(slave_be[s]), 128'(master_be[exp_m]));
        lat = $urandom_range(0, 3);
        for (int l = 0; l < lat; l++) begin
          // Other slaves may raise ready; it must be ignored.
          slave_ready = 4'($urandom) & ~(4'b0001 << s);
          slave_rdata = {$urandom, $urandom, $urandom, $urandom};
          tick();
          chk("rnd_wait", 128'({slave_req, master_ready}), 128'({4'b0001 << s, 3'b000}));
        end
        d = $urandom;
        slave_ready = 4'($urandom) | (4'b0001 << s);
        slave_rdata = {$urandom, $urandom, $urandom, $urandom};
        slave_rdata[s] = d;
        tick();
        chk("rnd_ready", 128'(master_ready), 128'(1) << exp_m);
        chk("rnd_err", 128'(master_err), 128'(0));
        chk("rnd_rdata", 128'(master_rdata), 128'(d) << (32 * exp_m));
        chk("rnd_resp_slave_idle", 128'(slave_req), 128'(0));
      end
      slave_ready = '0;
      if ($urandom_range(0, 1) == 1) new_req(exp_m);
      else master_req[exp_m] = 1'b0;
      tick();
      chk("rnd_idle_quiet", 128'(all_zero()), 128'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
